// File: rtl/interrupt_controller.sv
// Interrupt controller: latches detector pulses, arbitrates by IP level then index,
// presents a vectored request at instruction boundaries and tracks 8051 nesting levels.
module interrupt_controller #(
  parameter int          N_SRC      = 5,
  parameter logic [15:0] VEC_BASE   = 16'h0003,
  parameter logic [15:0] VEC_STRIDE = 16'h0008
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SRC-1:0] i_pend,
  input  logic [N_SRC-1:0] i_ip,
  input  logic             i_instr_end,
  input  logic             i_ack,
  input  logic             i_reti,
  output logic             o_req,
  output logic [15:0]      o_vector,
  output logic [2:0]       o_src,
  output logic [N_SRC-1:0] o_clr,
  output logic [1:0]       o_isr_lvl,
  output logic             o_in_service
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  localparam logic [N_SRC-1:0] ONE_HOT0 = N_SRC'(1);

  state_t           state_q, state_d;
  logic [N_SRC-1:0] latched_q, latched_d;
  logic [1:0]       isr_lvl_q, isr_lvl_d;
  logic             reti_hold_q, reti_hold_d;
  logic [2:0]       src_q, src_d;
  logic [15:0]      vector_q, vector_d;
  logic [N_SRC-1:0] clr_q, clr_d;

  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] pool;
  logic [2:0]       sel;

  // High-level candidates shadow low ones; lowest index wins inside the chosen pool.
  always_comb begin
    elig = '0;
    for (int i = 0; i < N_SRC; i++) begin
      elig[i] = latched_q[i] & ((isr_lvl_q == 2'b00) | (i_ip[i] & (isr_lvl_q == 2'b01)));
    end
    pool = (|(elig & i_ip)) ? (elig & i_ip) : elig;
    sel  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pool[i]) sel = 3'(i);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      latched_q   <= '0;
      isr_lvl_q   <= 2'b00;
      reti_hold_q <= 1'b0;
      src_q       <= 3'd0;
      vector_q    <= VEC_BASE;
      clr_q       <= '0;
    end else begin
      state_q     <= state_d;
      latched_q   <= latched_d;
      isr_lvl_q   <= isr_lvl_d;
      reti_hold_q <= reti_hold_d;
      src_q       <= src_d;
      vector_q    <= vector_d;
      clr_q       <= clr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    latched_d   = latched_q;
    isr_lvl_d   = isr_lvl_q;
    src_d       = src_q;
    vector_d    = vector_q;
    clr_d       = '0;
    reti_hold_d = reti_hold_q;

    // RETI retires the older level before an ack in the same cycle sets the new one.
    if (i_reti) begin
      if (isr_lvl_q[1]) isr_lvl_d[1] = 1'b0;
      else              isr_lvl_d[0] = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (i_instr_end && (|elig) && !reti_hold_q && !i_reti) begin
          state_d  = REQ;
          src_d    = sel;
          vector_d = VEC_BASE + (16'(sel) * VEC_STRIDE);
        end
      end
      REQ: begin
        if (i_ack) begin
          state_d               = IDLE;
          isr_lvl_d[i_ip[src_q]] = 1'b1;
          latched_d[src_q]      = 1'b0;
          clr_d                 = ONE_HOT0 << src_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_reti)           reti_hold_d = 1'b1;
    else if (i_instr_end) reti_hold_d = 1'b0;

    latched_d = latched_d | i_pend;
  end

  assign o_req        = (state_q == REQ);
  assign o_src        = src_q;
  assign o_vector     = vector_q;
  assign o_clr        = clr_q;
  assign o_isr_lvl    = isr_lvl_q;
  assign o_in_service = |isr_lvl_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios then random traffic, all outputs
// compared every cycle against a priority/nesting reference model.
module tb_interrupt_controller;

  localparam int N = 5;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [N-1:0] i_pend;
  logic [N-1:0] i_ip;
  logic         i_instr_end;
  logic         i_ack;
  logic         i_reti;
  logic         o_req;
  logic [15:0]  o_vector;
  logic [2:0]   o_src;
  logic [N-1:0] o_clr;
  logic [1:0]   o_isr_lvl;
  logic         o_in_service;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit m_lat [N];
  bit m_hi, m_lo, m_hold, m_req;
  int m_src;
  int m_clr_src;

  interrupt_controller dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pend(i_pend), .i_ip(i_ip),
    .i_instr_end(i_instr_end), .i_ack(i_ack), .i_reti(i_reti),
    .o_req(o_req), .o_vector(o_vector), .o_src(o_src), .o_clr(o_clr),
    .o_isr_lvl(o_isr_lvl), .o_in_service(o_in_service)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit eligible(int i);
    if (!m_lat[i]) return 0;
    if (!m_hi && !m_lo) return 1;
    return i_ip[i] && !m_hi && m_lo;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit new_hi, new_lo;
    int pick;
    if (i_rst) begin
      foreach (m_lat[i]) m_lat[i] = 0;
      m_hi = 0; m_lo = 0; m_hold = 0; m_req = 0; m_src = 0; m_clr_src = -1;
      return;
    end
    new_hi = m_hi; new_lo = m_lo;
    if (i_reti) begin
      if (new_hi) new_hi = 0;
      else        new_lo = 0;
    end
    m_clr_src = -1;
    if (m_req) begin
      if (i_ack) begin
        m_req = 0;
        if (i_ip[m_src]) new_hi = 1; else new_lo = 1;
        m_lat[m_src] = 0;
        m_clr_src = m_src;
      end
    end else if (i_instr_end && !m_hold && !i_reti) begin
      pick = -1;
      for (int lvl = 1; lvl >= 0 && pick < 0; lvl--)
        for (int i = 0; i < N && pick < 0; i++)
          if (eligible(i) && (int'(i_ip[i]) == lvl)) pick = i;
      if (pick >= 0) begin
        m_req = 1;
        m_src = pick;
      end
    end
    if (i_reti) m_hold = 1;
    else if (i_instr_end) m_hold = 0;
    for (int i = 0; i < N; i++) if (i_pend[i]) m_lat[i] = 1;
    m_hi = new_hi; m_lo = new_lo;
  endtask

  task automatic compare_all();
    logic [N-1:0] exp_clr;
    exp_clr = '0;
    if (m_clr_src >= 0) exp_clr[m_clr_src] = 1'b1;
    chk("req", 32'(o_req), 32'(m_req));
    chk("src", 32'(o_src), 32'(m_src));
    chk("vector", 32'(o_vector), 32'(3 + 8 * m_src));
    chk("clr", 32'(o_clr), 32'(exp_clr));
    chk("isr_lvl", 32'(o_isr_lvl), 32'({m_hi, m_lo}));
    chk("in_service", 32'(o_in_service), 32'(m_hi | m_lo));
  endtask

  task automatic cyc(input logic [N-1:0] pend, input logic [N-1:0] ip, input logic iend,
                     input logic ack, input logic reti, input logic rst);
    i_pend = pend; i_ip = ip; i_instr_end = iend; i_ack = ack; i_reti = reti; i_rst = rst;
    @(posedge i_clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    logic [N-1:0] rp, rip;
    logic         rie, rack, rreti, rrst;
    i_pend = '0; i_ip = '0; i_instr_end = 0; i_ack = 0; i_reti = 0; i_rst = 1;
    @(posedge i_clk); #1;
    cyc(5'b00000, 5'b00000, 0, 0, 0, 1);
    chk("reset_vector", 32'(o_vector), 32'h0003);
    chk("reset_req", 32'(o_req), 32'h0);

    // 1: single low source
    cyc(5'b00001, 5'b00000, 1, 0, 0, 0);
    chk("t1_no_req_same_edge", 32'(o_req), 32'h0);
    cyc(5'b00000, 5'b00000, 1, 0, 0, 0);
    chk("t1_vector", 32'(o_vector), 32'h0003);
    cyc(5'b00000, 5'b00000, 0, 1, 0, 0);
    chk("t1_clr", 32'(o_clr), 32'h01);
    chk("t1_isr", 32'(o_isr_lvl), 32'h1);
    cyc(5'b00000, 5'b00000, 0, 0, 0, 0);
    chk("t1_clr_pulse", 32'(o_clr), 32'h00);
    cyc(5'b00000, 5'b00000, 0, 0, 1, 0);
    cyc(5'b00000, 5'b00000, 1, 0, 0, 0);

    // 2: simultaneous pulses, IP selects source 2 first
    cyc(5'b00110, 5'b00100, 0, 0, 0, 0);
    cyc(5'b00000, 5'b00100, 1, 0, 0, 0);
    chk("t2_first_vector", 32'(o_vector), 32'h0013);
    cyc(5'b00000, 5'b00100, 0, 1, 0, 0);
    cyc(5'b00000, 5'b00100, 0, 0, 1, 0);
    cyc(5'b00000, 5'b00100, 1, 0, 0, 0);
    chk("t2_hold_blocks", 32'(o_req), 32'h0);
    cyc(5'b00000, 5'b00100, 1, 0, 0, 0);
    chk("t2_second_vector", 32'(o_vector), 32'h000B);
    cyc(5'b00000, 5'b00100, 0, 1, 0, 0);
    cyc(5'b00000, 5'b00100, 0, 0, 1, 0);
    cyc(5'b00000, 5'b00100, 1, 0, 0, 0);

    // 3: high preempts low ISR; low pulse waits for both RETIs
    cyc(5'b00010, 5'b10000, 1, 0, 0, 0);
    cyc(5'b00000, 5'b10000, 1, 0, 0, 0);
    cyc(5'b00000, 5'b10000, 0, 1, 0, 0);
    cyc(5'b10000, 5'b10000, 1, 0, 0, 0);
    cyc(5'b00000, 5'b10000, 1, 0, 0, 0);
    chk("t3_vector", 32'(o_vector), 32'h0023);
    cyc(5'b00001, 5'b10000, 0, 1, 0, 0);
    chk("t3_isr_both", 32'(o_isr_lvl), 32'h3);
    for (int k = 0; k < 3; k++) cyc(5'b00000, 5'b10000, 1, 0, 0, 0);
    cyc(5'b00000, 5'b10000, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) cyc(5'b00000, 5'b10000, 1, 0, 0, 0);
    chk("t3_low_blocked", 32'(o_req), 32'h0);
    cyc(5'b00000, 5'b10000, 0, 0, 1, 0);
    cyc(5'b00000, 5'b10000, 1, 0, 0, 0);
    cyc(5'b00000, 5'b10000, 1, 0, 0, 0);
    cyc(5'b00000, 5'b10000, 0, 1, 0, 0);
    cyc(5'b00000, 5'b10000, 0, 0, 1, 0);

    // 4: RETI with TF1 latched
    cyc(5'b01000, 5'b00000, 0, 0, 0, 0);
    cyc(5'b00000, 5'b00000, 0, 0, 1, 0);
    cyc(5'b00000, 5'b00000, 1, 0, 0, 0);
    cyc(5'b00000, 5'b00000, 1, 0, 0, 0);
    chk("t4_vector", 32'(o_vector), 32'h001B);
    cyc(5'b00000, 5'b00000, 0, 1, 0, 0);
    cyc(5'b00000, 5'b00000, 0, 0, 1, 0);

    // 5: pulse held across 10 non-boundary cycles, then reset in REQ
    cyc(5'b00001, 5'b00000, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) cyc(5'b00000, 5'b00000, 0, 0, 0, 0);
    cyc(5'b00000, 5'b00000, 1, 0, 0, 0);
    cyc(5'b00000, 5'b00000, 0, 0, 0, 1);
    chk("t5_reset_req", 32'(o_req), 32'h0);

    // 6: high ISR blocks high pulse; RETI when idle is a no-op
    cyc(5'b00001, 5'b00001, 1, 0, 0, 0);
    cyc(5'b00000, 5'b00001, 1, 0, 0, 0);
    cyc(5'b00001, 5'b00001, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(5'b00000, 5'b00001, 1, 0, 0, 0);
    cyc(5'b00000, 5'b00001, 0, 0, 1, 0);
    cyc(5'b00000, 5'b00001, 1, 0, 0, 0);
    cyc(5'b00000, 5'b00001, 1, 0, 0, 0);
    cyc(5'b00000, 5'b00001, 0, 1, 1, 0);
    cyc(5'b00000, 5'b00001, 0, 0, 1, 0);
    cyc(5'b00000, 5'b00001, 0, 0, 1, 0);
    chk("t6_reti_noop", 32'(o_isr_lvl), 32'h0);

    // random traffic
    rip = 5'b00000;
    for (int k = 0; k < 600; k++) begin
      rp    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b00000;
      if ($urandom_range(0, 15) == 0) rip = 5'($urandom);
      rie   = 1'($urandom);
      rack  = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      rreti = ($urandom_range(0, 7) == 0);
      rrst  = ($urandom_range(0, 150) == 0);
      cyc(rp, rip, rie, rack, rreti, rrst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
